// File: rtl/prod_bcd_converter.sv
// -----------------------------------------------------------------------------
// prod_bcd_converter
//
// Sequential signed-binary to BCD converter that sits behind the Booth
// multiplier. A rising edge on start (the multiplier's DONE) captures the
// two's-complement product. The block then converts its magnitude with an
// iterative shift-add-3 (double-dabble) datapath, one product bit per clock.
// It publishes a sign bit plus packed BCD digits for the display driver.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        asynchronous active-low reset (0 = reset)
//   start      conversion request, rising-edge triggered, accepted only in IDLE
//   prod       signed product, sampled on the accepted start edge
//   sign       1 = last converted result was negative
//   bcd        packed BCD magnitude of the last result, bits [3:0] = units
//   bcd_valid  one-cycle pulse in the cycle sign/bcd take a new value
//   busy       high from the accepted start until bcd_valid inclusive
//
// Timing (PW = 8): accept edge E0, ABS at E1, shifts at E2..E9, OUT
// publishes at E10. bcd_valid is therefore high in the cycle after E10, and
// busy drops at E11. The earliest next accepted edge is E11.
//
// DIGITS must satisfy 10^DIGITS > 2^(PW-1) so that the most negative product
// (magnitude 2^(PW-1)) fits in the scratch register.
// -----------------------------------------------------------------------------
module prod_bcd_converter #(
  parameter int PW     = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PW-1:0]         prod,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(PW + 1);

  localparam logic [CW-1:0] CNT_LOAD = CW'(PW);
  localparam logic [CW-1:0] CNT_LAST = CW'(32'd1);
  localparam logic [PW-1:0] PW_ONE   = PW'(32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Double-dabble correction: every BCD digit that is 5 or more gets 3 added,
  // so that the following left shift carries correctly into the next digit.
  // ---------------------------------------------------------------------------
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] digits);
    logic [BW-1:0] adj;
    adj = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = digits[4*i +: 4];
      end
    end
    return adj;
  endfunction

  // ---------------------------------------------------------------------------
  // Two's-complement magnitude as a PW-bit unsigned value. The most negative
  // product maps onto itself, and read as unsigned that is exactly 2^(PW-1).
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] twos_magnitude(input logic [PW-1:0] value);
    logic [PW-1:0] mag;
    if (value[PW-1]) begin
      mag = ~value + PW_ONE;
    end else begin
      mag = value;
    end
    return mag;
  endfunction

  state_t           state_r;
  logic             start_q_r;
  logic [PW-1:0]    prod_r;
  logic             neg_r;
  logic [PW-1:0]    mag_r;
  logic [BW-1:0]    scratch_r;
  logic [CW-1:0]    cnt_r;

  logic             start_edge_s;
  logic [BW-1:0]    adj_scratch_s;
  logic [BW-1:0]    next_scratch_s;
  logic [PW-1:0]    next_mag_s;
  logic [PW-1:0]    abs_mag_s;

  // Start edge detect and next-step datapath values for the shift stage.
  always_comb begin
    start_edge_s   = start & ~start_q_r;
    abs_mag_s      = twos_magnitude(prod_r);
    adj_scratch_s  = dabble_adjust(scratch_r);
    // {scratch, mag} shifted left by one: the MSB of mag moves into the units digit.
    next_scratch_s = {adj_scratch_s[BW-2:0], mag_r[PW-1]};
    next_mag_s     = {mag_r[PW-2:0], 1'b0};
  end

  // Control FSM, conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      start_q_r <= 1'b0;
      prod_r    <= '0;
      neg_r     <= 1'b0;
      mag_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      sign      <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // The edge history tracks start in every state, so a level held
      // through a conversion never looks like a fresh request afterwards.
      start_q_r <= start;
      bcd_valid <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            prod_r  <= prod;
            busy    <= 1'b1;
            state_r <= ABS;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end

        ABS: begin
          neg_r     <= prod_r[PW-1];
          mag_r     <= abs_mag_s;
          scratch_r <= '0;
          cnt_r     <= CNT_LOAD;
          state_r   <= SHIFT;
        end

        SHIFT: begin
          scratch_r <= next_scratch_s;
          mag_r     <= next_mag_s;
          cnt_r     <= cnt_r - CNT_LAST;
          // The shift consuming the last magnitude bit ends the loop.
          if (cnt_r == CNT_LAST) begin
            state_r <= OUT;
          end else begin
            state_r <= SHIFT;
          end
        end

        OUT: begin
          // A zero magnitude always comes from a non-negative product, so
          // no negative zero can be published.
          sign      <= neg_r;
          bcd       <= scratch_r;
          bcd_valid <= 1'b1;
          busy      <= 1'b1;
          state_r   <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_bcd_converter.sv
module tb_prod_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  prod;
  logic        sign;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  prod_bcd_converter #(.PW(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prod      (prod),
    .sign      (sign),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign from the MSB, magnitude by integer arithmetic, digits by div/mod.
  task automatic model(input logic [7:0] p, output logic s, output logic [11:0] b);
    int m;
    s = p[7];
    m = p[7] ? (256 - int'(p)) : int'(p);
    b = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endtask

  // Pulse start for one cycle with product p, then observe 24 cycles.
  // lat is the negedge index (0 = just after the sampling edge) of the first
  // bcd_valid. early flags a sign/bcd change before that pulse.
  task automatic do_conv(input logic [7:0] p, output logic s, output logic [11:0] b,
                         output int lat, output int pulses, output int busy_cyc,
                         output bit early);
    logic        s0;
    logic [11:0] b0;
    @(negedge clk);
    prod  = p;
    start = 1'b1;
    s0 = sign; b0 = bcd; s = sign; b = bcd;
    lat = -1; pulses = 0; busy_cyc = 0; early = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      prod  = 8'($urandom);
      if (busy) busy_cyc++;
      if (bcd_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k; s = sign; b = bcd;
        end
      end else if (lat < 0 && (sign !== s0 || bcd !== b0)) begin
        early = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    logic s; logic [11:0] b; int lat, pulses, bc; bit early;
    rst = 1'b1; start = 1'b0; prod = 8'h00;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sign, bcd, bcd_valid, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_init: got sign=%b bcd=%h v=%b busy=%b expected all 0", sign, bcd, bcd_valid, busy);
    end
    @(negedge clk); rst = 1'b1;
    // Leave non-zero outputs, then reset mid-conversion with start held high.
    do_conv(8'hC8, s, b, lat, pulses, bc, early);
    @(negedge clk); prod = 8'h33; start = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: got busy=%b expected 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sign, bcd, bcd_valid, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: got sign=%b bcd=%h v=%b busy=%b expected all 0", sign, bcd, bcd_valid, busy);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic;
    logic s, es; logic [11:0] b, eb; int lat, pulses, bc; bit early;
    model(8'h15, es, eb);
    do_conv(8'h15, s, b, lat, pulses, bc, early);
    checks++;
    if (lat !== 10 || pulses !== 1) begin
      errors++;
      $display("FAIL basic_timing: got lat=%0d pulses=%0d expected lat=10 pulses=1", lat, pulses);
    end
    checks++;
    if (bc !== 11) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles expected 11", bc);
    end
    checks++;
    if (s !== es || b !== eb || b !== 12'h021) begin
      errors++;
      $display("FAIL basic_value: got sign=%b bcd=%h expected sign=%b bcd=%h", s, b, es, eb);
    end
  endtask

  task automatic test_hold;
    logic s; logic [11:0] b; int lat, pulses, bc; bit early;
    do_conv(8'hC8, s, b, lat, pulses, bc, early);
    checks++;
    if (s !== 1'b1 || b !== 12'h056 || lat !== 10) begin
      errors++;
      $display("FAIL hold_neg: got sign=%b bcd=%h lat=%0d expected 1/056/10", s, b, lat);
    end
    checks++;
    if (sign !== 1'b1 || bcd !== 12'h056) begin
      errors++;
      $display("FAIL hold_idle: got sign=%b bcd=%h expected 1/056", sign, bcd);
    end
    do_conv(8'h40, s, b, lat, pulses, bc, early);
    checks++;
    if (s !== 1'b0 || b !== 12'h064 || early !== 1'b0) begin
      errors++;
      $display("FAIL hold_pos: got sign=%b bcd=%h early=%b expected 0/064/0", s, b, early);
    end
  endtask

  task automatic test_boundaries;
    logic [7:0]  pv [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [12:0] xv [4] = '{13'h1128, 13'h0127, 13'h0000, 13'h1001};
    logic s; logic [11:0] b; int lat, pulses, bc; bit early;
    for (int i = 0; i < 4; i++) begin
      do_conv(pv[i], s, b, lat, pulses, bc, early);
      checks++;
      if ({s, b} !== xv[i] || lat !== 10 || pulses !== 1) begin
        errors++;
        $display("FAIL boundary_%h: got sign=%b bcd=%h lat=%0d expected sign=%b bcd=%h lat=10",
                 pv[i], s, b, lat, xv[i][12], xv[i][11:0]);
      end
    end
  endtask

  task automatic test_level_start;
    int pulses; logic [11:0] b;
    @(negedge clk); prod = 8'h09; start = 1'b1;
    pulses = 0; b = 12'hFFF;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      prod = 8'($urandom);
      if (bcd_valid) begin pulses++; b = bcd; end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pulses !== 1 || b !== 12'h009) begin
      errors++;
      $display("FAIL level_hold: got pulses=%0d bcd=%h expected 1/009", pulses, b);
    end
    @(negedge clk); prod = 8'h0C; start = 1'b1;
    pulses = 0; b = 12'hFFF;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 3) start = 1'b1;
      else if (k == 0 || k == 6) start = 1'b0;
      if (bcd_valid) begin pulses++; b = bcd; end
    end
    checks++;
    if (pulses !== 1 || b !== 12'h012) begin
      errors++;
      $display("FAIL busy_edge_drop: got pulses=%0d bcd=%h expected 1/012", pulses, b);
    end
  endtask

  task automatic test_reset_mid;
    logic s; logic [11:0] b; int lat, pulses, bc, bad; bit early;
    @(negedge clk); prod = 8'h21; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bcd_valid !== 1'b0 || bcd !== 12'h000 || sign !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_shift: got %0d cycles with activity expected 0", bad);
    end
    do_conv(8'hF1, s, b, lat, pulses, bc, early);
    checks++;
    if (s !== 1'b1 || b !== 12'h015 || lat !== 10) begin
      errors++;
      $display("FAIL reset_recover: got sign=%b bcd=%h lat=%0d expected 1/015/10", s, b, lat);
    end
  endtask

  task automatic test_random;
    logic s, es; logic [11:0] b, eb; int lat, pulses, bc; bit early;
    logic [7:0] p;
    for (int i = 0; i < 20; i++) begin
      p = 8'($urandom);
      model(p, es, eb);
      do_conv(p, s, b, lat, pulses, bc, early);
      checks++;
      if (s !== es || b !== eb || lat !== 10 || pulses !== 1 || bc !== 11 || early) begin
        errors++;
        $display("FAIL random_%h: got sign=%b bcd=%h lat=%0d pulses=%0d busy=%0d early=%b expected sign=%b bcd=%h lat=10 pulses=1 busy=11",
                 p, s, b, lat, pulses, bc, early, es, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_boundaries();
    test_level_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
